axi4_lite_slave_regfile: RTL and testbench
==========================================

Name: axi4_lite_slave_regfile

Overview:
- AXI4-Lite slave register file.
- Sits directly downstream of the team's AXI4-Lite master and terminates its AW/W/B/AR/R channels.
- Holds NUM_REGS 32-bit software-visible registers with byte-strobed writes and registered read-back.
- Exposes all register contents as a flat vector for the surrounding control logic.

Parameters:
- NUM_REGS, 16, number of 32-bit registers, power of two, 2..256.
- ADDR_W, 32, width of AWADDR/ARADDR.

Ports:
- ARESETn  in  1  asynchronous active-low reset.
- ACLK  in  1  single clock; all logic is on the rising edge.
- AWADDR  in  ADDR_W  write address.
- AWCACHE  in  4  ignored.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- ARADDR  in  ADDR_W  read address.
- ARCACHE  in  4  ignored.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- REG_Q  out  NUM_REGS*32  register contents; register i occupies bits [32i+31:32i].

Behaviour:
- Reset (asynchronous, ARESETn low):
  - All registers cleared to 0.
  - AWREADY, WREADY, ARREADY reset to 1.
  - BVALID and RVALID reset to 0.
  - BRESP, RRESP and RDATA reset to 0.
  - Any in-flight transaction is dropped. No response is issued after reset release.
- Address decode:
  - Byte address; bits [1:0] are ignored.
  - index = ADDR[2 +: log2(NUM_REGS)].
  - Address is in range iff ADDR[ADDR_W-1 : 2+log2(NUM_REGS)] == 0.
- Write path, states WR_COLLECT and WR_RESP:
  - WR_COLLECT: AW and W are accepted independently, in either order or in the same cycle.
    - The AW handshake latches the address and drops AWREADY.
    - The W handshake latches data and strobes and drops WREADY.
  - When both are latched, the commit occurs on the next edge.
    - In range: bytes with WSTRB[b]=1 are updated; the others hold. BRESP=00.
    - Out of range: no register changes. BRESP=10.
    - BVALID=1; go to WR_RESP.
    - Latency: last of AW/W handshake at edge N -> register update and BVALID at edge N+1.
  - WR_RESP: BVALID, BRESP held stable until BVALID&&BREADY.
    - Then BVALID=0, AWREADY=WREADY=1, return to WR_COLLECT.
  - At most one outstanding write. AWREADY and WREADY stay low throughout WR_RESP.
  - WSTRB=0000 with an in-range address is a legal no-op write and returns OKAY.
- Read path, states RD_IDLE and RD_DATA:
  - RD_IDLE: ARREADY=1. An AR handshake at edge N gives RVALID=1 at edge N+1 and ARREADY=0.
    - RDATA = register value sampled at edge N, i.e. before any write committing on that same edge.
    - Out-of-range read: RDATA=0, RRESP=10.
  - RD_DATA: RDATA, RRESP held until RVALID&&RREADY. Then RVALID=0, ARREADY=1.
- Read and write paths are fully independent. Simultaneous AR and AW/W handshakes are allowed.
- Same-register collision: the read returns the pre-write value and the write still commits.
- REG_Q reflects a commit from the edge after it, together with BVALID.
- Responses never assert without a prior handshake. VALID outputs never drop without the matching READY.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
  - typedef enum for wr_state_t {WR_COLLECT, WR_RESP}.
  - typedef enum for rd_state_t {RD_IDLE, RD_DATA}.
- The master reuses the same package.
- One natural sub-module: axi4_lite_addr_decode (combinational) takes ADDR and NUM_REGS and returns index and in_range. It is instanced once each for the write and read paths.

Test Plan:
- AW@0x4 one cycle, then W data 0xDEADBEEF WSTRB=1111 two cycles later, BREADY=1 -> BVALID one cycle after the W handshake, BRESP=00, REG_Q[63:32]=0xDEADBEEF; then AR@0x4 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=00.
- Reg 0 = 0x11223344; write 0xAABBCCDD WSTRB=0101 with AW and W in the same cycle -> reg 0 = 0x11BB33DD.
- Write @0x40 and read @0x100 with NUM_REGS=16 -> BRESP=10 and no register change; RRESP=10 and RDATA=0.
- Hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID/RVALID and their data stay stable; AWREADY/WREADY/ARREADY stay 0 until the response handshake completes.
- AR@0x8 and commit of write 0x5 to 0x8 on the same edge, old value 0x0 -> RDATA=0x0, register becomes 0x5, and a following read returns 0x5.
- Assert ARESETn low while BVALID=1 and reg 3 = 0x1234 -> all registers 0, BVALID=RVALID=0, all READYs=1; no response is issued after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel state encodings.
// Latency: none, declarations only.
// Backpressure: not applicable.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One-bit encodings keep the state registers identical to the older flops
    typedef enum logic [0:0] {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle between the master and the register file.
// Latency: none, wiring only.
// Backpressure: carried by the per-channel VALID/READY pairs.
interface axi4_lite_slave_regfile_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] AWADDR;
    logic [3:0]        AWCACHE;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARCACHE;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWCACHE, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARCACHE, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWCACHE, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARCACHE, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to register index plus in-range flag for a NUM_REGS word file.
// Latency: combinational.
// Backpressure: not applicable.
module axi4_lite_addr_decode #(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic [ADDR_W-1:0]           addr,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        in_range
);
    localparam int IDX_W = $clog2(NUM_REGS);

    // Word-aligned access: the byte-lane bits never select anything
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[1:0];

    assign idx      = addr[2 +: IDX_W];
    assign in_range = (addr[ADDR_W-1:2+IDX_W] == '0);
endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave holding NUM_REGS byte-strobed 32-bit registers, flat view on REG_Q.
// Latency: write commits / BVALID one edge after last AW-W handshake; RVALID one edge after AR.
// Backpressure: one write and one read outstanding; READYs stay low until B/R handshake.
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi4_lite_slave_regfile_if.slave s_axi,
    output logic [NUM_REGS*32-1:0]   REG_Q
);
    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t         wr_state;
    rd_state_t         rd_state;
    logic [ADDR_W-1:0] aw_addr;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_commit;
    logic [31:0]       regs [NUM_REGS];

    // Cache/protection attributes carry no meaning for a plain register file
    logic unused_attrs;
    assign unused_attrs = ^{s_axi.AWCACHE, s_axi.AWPROT, s_axi.ARCACHE, s_axi.ARPROT};

    // Write decode works on the latched address, read decode on the live ARADDR
    axi4_lite_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wr_decode (
        .addr     (aw_addr),
        .idx      (wr_idx),
        .in_range (wr_in_range)
    );

    axi4_lite_addr_decode #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd_decode (
        .addr     (s_axi.ARADDR),
        .idx      (rd_idx),
        .in_range (rd_in_range)
    );

    // Both READYs low while collecting means address and data are both held
    assign wr_commit = (wr_state == WR_COLLECT) && !awready_q && !wready_q;

    // Write channel: collect AW and W independently, then respond on B
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state  <= WR_COLLECT;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
        end else begin
            case (wr_state)
                WR_COLLECT: begin
                    if (s_axi.AWVALID && awready_q) begin
                        aw_addr   <= s_axi.AWADDR;
                        awready_q <= 1'b0;
                    end
                    if (s_axi.WVALID && wready_q) begin
                        w_data   <= s_axi.WDATA;
                        w_strb   <= s_axi.WSTRB;
                        wready_q <= 1'b0;
                    end
                    if (wr_commit) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WR_COLLECT;
                    end
                end
                default: wr_state <= WR_COLLECT;
            endcase
        end
    end

    // Register storage: byte-lane update on an in-range commit
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel: sample the register on the AR edge, so a same-edge write is not seen
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s_axi.ARVALID) begin
                        rdata_q   <= rd_in_range ? regs[rd_idx] : '0;
                        rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RDATA   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign REG_Q[32*g +: 32] = regs[g];
    end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench: directed vector table, hand-built corner sequences, random traffic.
module tb_axi4_lite_slave_regfile;
    localparam int NR = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [NR*32-1:0] REG_Q;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave_regfile_if #(.ADDR_W(32)) bus ();

    axi4_lite_slave_regfile #(.NUM_REGS(NR), .ADDR_W(32)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi   (bus),
        .REG_Q   (REG_Q)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model [NR];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a plain word array addressed by byte address / 4
    function automatic bit m_in_range(input logic [31:0] a);
        return a < NR * 4;
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f = '0;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (!m_in_range(a)) return 2'b10;
        idx = int'(a / 4);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return m_in_range(a) ? model[int'(a / 4)] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] a);
        return m_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int da, input int dw, input int bstall, output logic [1:0] resp);
        int c = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        logic [1:0] er;
        resp = 2'bxx;
        while (!(aw_done && w_done) && c < 100) begin
            @(negedge ACLK);
            bus.AWADDR  = addr;
            bus.WDATA   = data;
            bus.WSTRB   = strb;
            bus.BREADY  = 1'b0;
            bus.AWVALID = (c >= da) && !aw_done;
            bus.WVALID  = (c >= dw) && !w_done;
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge ACLK);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            c++;
        end
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (!(aw_done && w_done)) return;
        chk("bvalid_not_early", bus.BVALID, 1'b0);
        er = model_write(addr, data, strb);
        @(negedge ACLK);
        chk("bvalid_latency", bus.BVALID, 1'b1);
        chk("bresp", bus.BRESP, er);
        chk("reg_q_after_commit", REG_Q, model_flat());
        chk("aw_w_ready_low_in_resp", {bus.AWREADY, bus.WREADY}, 2'b00);
        resp = bus.BRESP;
        for (int i = 0; i < bstall; i++) begin
            @(negedge ACLK);
            chk("b_stall_stable", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, er, 2'b00});
        end
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        chk("b_done", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rstall,
                            output logic [31:0] d, output logic [1:0] r);
        int c = 0;
        bit hs = 0, hs_now;
        logic [31:0] ed;
        logic [1:0] er;
        d = 'x;
        r = 'x;
        while (!hs && c < 100) begin
            @(negedge ACLK);
            bus.RREADY  = 1'b0;
            bus.ARADDR  = addr;
            bus.ARVALID = 1'b1;
            hs_now = bus.ARREADY;
            ed = exp_rdata(addr);
            er = exp_rresp(addr);
            @(posedge ACLK);
            hs = hs_now;
            c++;
        end
        chk("ar_accept", hs, 1'b1);
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        if (!hs) return;
        chk("rvalid_latency", {bus.RVALID, bus.ARREADY}, 2'b10);
        chk("rdata_model", bus.RDATA, ed);
        chk("rresp_model", bus.RRESP, er);
        d = bus.RDATA;
        r = bus.RRESP;
        for (int i = 0; i < rstall; i++) begin
            @(negedge ACLK);
            chk("r_stall_stable", {bus.RVALID, bus.ARREADY, bus.RDATA, bus.RRESP}, {2'b10, ed, er});
        end
        bus.RREADY = 1'b1;
        @(negedge ACLK);
        bus.RREADY = 1'b0;
        chk("r_done", {bus.RVALID, bus.ARREADY}, 2'b01);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          da;
        int          dw;
        int          bstall;
        int          rstall;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, a;

        vecs[0] = '{32'h4,   32'hDEADBEEF, 4'hF, 0, 2, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h0,   32'h11223344, 4'hF, 1, 0, 0, 0, 2'b00, 32'h11223344, 2'b00};
        vecs[2] = '{32'h0,   32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 2'b00, 32'h11BB33DD, 2'b00};
        vecs[3] = '{32'h40,  32'hFFFFFFFF, 4'hF, 0, 1, 0, 0, 2'b10, 32'h0,        2'b10};
        vecs[4] = '{32'h3C,  32'h12345678, 4'h0, 3, 1, 0, 0, 2'b00, 32'h0,        2'b00};
        vecs[5] = '{32'h3F,  32'hCAFEF00D, 4'h8, 0, 0, 5, 5, 2'b00, 32'hCA000000, 2'b00};
        vecs[6] = '{32'h100, 32'h55555555, 4'hF, 2, 2, 0, 0, 2'b10, 32'h0,        2'b10};
        vecs[7] = '{32'h4,   32'h9999AAAA, 4'h3, 0, 0, 0, 0, 2'b00, 32'hDEADAAAA, 2'b00};

        bus.AWADDR = '0; bus.AWCACHE = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARCACHE = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        model_clear();

        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("reset_reg_q", REG_Q, '0);
        chk("reset_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        chk("reset_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        chk("reset_resp_data", {bus.BRESP, bus.RRESP, bus.RDATA}, '0);

        // Directed table: write, then read the same address back
        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].da, vecs[i].dw,
                      vecs[i].bstall, br);
            chk($sformatf("vec%0d_bresp", i), br, vecs[i].exp_bresp);
            axi_read(vecs[i].addr, vecs[i].rstall, rd, rr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_rresp);
        end

        // Read of reg 2 sampled on the same edge that commits 0x5 into it
        @(negedge ACLK);
        bus.AWADDR = 32'h8; bus.WDATA = 32'h5; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        @(negedge ACLK);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 32'h8; bus.ARVALID = 1'b1;
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        chk("coll_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        chk("coll_rdata_old", bus.RDATA, 32'h0);
        chk("coll_reg_new", REG_Q[95:64], 32'h5);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        chk("coll_done", {bus.BVALID, bus.RVALID}, 2'b00);
        model[2] = 32'h5;
        axi_read(32'h8, 0, rd, rr);
        chk("coll_reread", rd, 32'h5);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h40 + ($urandom_range(0, 255) << 2);
            else a = ($urandom_range(0, NR - 1) << 2) | $urandom_range(0, 3);
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), br);
            if ($urandom_range(0, 7) == 0) a = 32'h40 + ($urandom_range(0, 255) << 2);
            else a = $urandom_range(0, NR - 1) << 2;
            axi_read(a, $urandom_range(0, 2), rd, rr);
        end

        // Reset while both a write response and a read response are pending
        axi_write(32'hC, 32'h1234, 4'hF, 0, 0, 0, br);
        @(negedge ACLK);
        bus.AWADDR = 32'h10; bus.WDATA = 32'hABCD; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'hC; bus.ARVALID = 1'b1;
        @(negedge ACLK);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        @(negedge ACLK);
        chk("pre_reset_pending", {bus.BVALID, bus.RVALID}, 2'b11);
        chk("pre_reset_reg3", REG_Q[127:96], 32'h1234);
        #2 ARESETn = 1'b0;
        #1;
        chk("async_reset_reg_q", REG_Q, '0);
        chk("async_reset_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        chk("async_reset_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        model_clear();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("no_resp_after_reset", {bus.BVALID, bus.RVALID}, 2'b00);
        end
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        axi_read(32'hC, 0, rd, rr);
        chk("reg3_cleared", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
